// File: rtl/ft601_pkg.sv
// Shared types and constants for the FT601 245-synchronous write path.
package ft601_pkg;

    localparam int FT601_DW  = 32;
    localparam int FT601_BEW = 4;
    localparam int ENTRY_W   = FT601_BEW + FT601_DW;
    localparam logic [FT601_BEW-1:0] BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [FT601_BEW-1:0] keep,
                                                      input logic [FT601_DW-1:0]  data);
        return {keep, data};
    endfunction

endpackage

// File: rtl/ft601_tx_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on rdata whenever not empty.
module ft601_tx_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             full_next
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok)
            count_nxt = count + 1'b1;
        else if (!push_ok && pop_ok)
            count_nxt = count - 1'b1;
    end

    // Lets the owner register a not-full flag that is exact on the following cycle.
    assign full_next = (count_nxt == (AW+1)'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ft601_tx_writer.sv
// FT601 write-direction streamer: elastic FIFO plus burst/gap scheduler driving the pins.
// Optional build macro FT601_TX_TESTPAT_EN adds an incrementing test-pattern source selected by TP_EN.
module ft601_tx_writer
    import ft601_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 1024,
    parameter int GAP_CYCLES = 4
) (
    input  logic        USB_DATA_CLK,
    input  logic        RST_N,
    input  logic [31:0] S_DATA,
    input  logic [3:0]  S_KEEP,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic        TP_EN,
    input  logic        USB_TXE_N,
    output logic        USB_WR_N,
    output logic [31:0] USB_DATA,
    output logic [3:0]  USB_BE,
    output logic        USB_RD_N,
    output logic        USB_OE_N,
    output logic [31:0] TX_COUNT
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    tx_state_t          state;
    tx_state_t          state_nxt;
    logic [BW-1:0]      burst_cnt;
    logic [BW-1:0]      burst_cnt_nxt;
    logic [GW-1:0]      gap_cnt;
    logic [GW-1:0]      gap_cnt_nxt;

    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_full_next;
    logic               s_ready_r;

    logic               wr_n_p0;
    logic [31:0]        data_p0;
    logic [3:0]         be_p0;
    logic [31:0]        tx_count_p0;

    logic               accepted;
    logic               hold;
    logic               can_start;
    logic               burst_last;
    logic               gap_last;

`ifdef FT601_TX_TESTPAT_EN
    logic [31:0] tp_cnt;

    assign fifo_push  = TP_EN ? ~fifo_full : (S_VALID & s_ready_r);
    assign fifo_wdata = TP_EN ? pack_entry(BE_ALL, tp_cnt) : pack_entry(S_KEEP, S_DATA);
    assign S_READY    = s_ready_r & ~TP_EN;

    always_ff @(posedge USB_DATA_CLK or negedge RST_N) begin
        if (!RST_N)
            tp_cnt <= '0;
        else if (TP_EN && !fifo_full)
            tp_cnt <= tp_cnt + 32'd1;
    end
`else
    logic tp_en_unused;

    assign tp_en_unused = TP_EN;
    assign fifo_push    = S_VALID & s_ready_r;
    assign fifo_wdata   = pack_entry(S_KEEP, S_DATA);
    assign S_READY      = s_ready_r;
`endif

    ft601_tx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (USB_DATA_CLK),
        .rst_n     (RST_N),
        .push      (fifo_push),
        .wdata     (fifo_wdata),
        .pop       (fifo_pop),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .full_next (fifo_full_next)
    );

    always_ff @(posedge USB_DATA_CLK or negedge RST_N) begin
        if (!RST_N)
            s_ready_r <= 1'b0;
        else
            s_ready_r <= ~fifo_full_next;
    end

    // A presented word that the FT601 did not take must stay on the bus untouched.
    assign accepted   = ~wr_n_p0 & ~USB_TXE_N;
    assign hold       = ~wr_n_p0 & USB_TXE_N;
    assign can_start  = ~fifo_empty & ~USB_TXE_N;
    assign burst_last = accepted && (burst_cnt == BW'(MAX_BURST - 1));
    assign gap_last   = (gap_cnt == GW'(GAP_CYCLES - 1));

    always_ff @(posedge USB_DATA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            burst_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        gap_cnt_nxt   = gap_cnt;
        case (state)
            IDLE: begin
                if (can_start) begin
                    state_nxt     = BURST;
                    burst_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (!hold) begin
                    if (burst_last) begin
                        state_nxt     = GAP;
                        burst_cnt_nxt = '0;
                        gap_cnt_nxt   = '0;
                    end else if (fifo_empty) begin
                        state_nxt     = IDLE;
                        burst_cnt_nxt = '0;
                    end else if (accepted) begin
                        burst_cnt_nxt = burst_cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                // The final gap cycle already acts as IDLE so the gap is exactly GAP_CYCLES long.
                if (gap_last) begin
                    gap_cnt_nxt   = '0;
                    burst_cnt_nxt = '0;
                    state_nxt     = can_start ? BURST : IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                burst_cnt_nxt = '0;
                gap_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            IDLE:    fifo_pop = can_start;
            BURST:   fifo_pop = ~hold & ~burst_last & ~fifo_empty;
            GAP:     fifo_pop = gap_last & can_start;
            default: fifo_pop = 1'b0;
        endcase
    end

    // Pin register stage: loads on pop, otherwise holds data and drives the strobe as required.
    always_ff @(posedge USB_DATA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_n_p0     <= 1'b1;
            data_p0     <= '0;
            be_p0       <= BE_ALL;
            tx_count_p0 <= '0;
        end else begin
            if (!hold) begin
                if (fifo_pop) begin
                    wr_n_p0 <= 1'b0;
                    data_p0 <= fifo_rdata[FT601_DW-1:0];
                    be_p0   <= fifo_rdata[ENTRY_W-1:FT601_DW];
                end else begin
                    wr_n_p0 <= 1'b1;
                end
            end
            if (accepted)
                tx_count_p0 <= tx_count_p0 + 32'd1;
        end
    end

    assign USB_WR_N = wr_n_p0;
    assign USB_DATA = data_p0;
    assign USB_BE   = be_p0;
    assign TX_COUNT = tx_count_p0;
    assign USB_RD_N = 1'b1;
    assign USB_OE_N = 1'b1;

endmodule

// File: tb/tb_ft601_tx_writer.sv
// Scoreboard bench for ft601_tx_writer: queued expected words checked by an independent bus monitor.
module tb_ft601_tx_writer;
    localparam int DEPTH = 8;
    localparam int MAXB  = 4;
    localparam int GAP   = 4;

    logic        clk = 1'b0;
    logic        RST_N;
    logic [31:0] S_DATA;
    logic [3:0]  S_KEEP;
    logic        S_VALID;
    logic        S_READY;
    logic        TP_EN;
    logic        USB_TXE_N;
    logic        USB_WR_N;
    logic [31:0] USB_DATA;
    logic [3:0]  USB_BE;
    logic        USB_RD_N;
    logic        USB_OE_N;
    logic [31:0] TX_COUNT;

    always #5 clk = ~clk;

    ft601_tx_writer #(
        .FIFO_DEPTH (DEPTH),
        .MAX_BURST  (MAXB),
        .GAP_CYCLES (GAP)
    ) dut (
        .USB_DATA_CLK (clk),
        .RST_N        (RST_N),
        .S_DATA       (S_DATA),
        .S_KEEP       (S_KEEP),
        .S_VALID      (S_VALID),
        .S_READY      (S_READY),
        .TP_EN        (TP_EN),
        .USB_TXE_N    (USB_TXE_N),
        .USB_WR_N     (USB_WR_N),
        .USB_DATA     (USB_DATA),
        .USB_BE       (USB_BE),
        .USB_RD_N     (USB_RD_N),
        .USB_OE_N     (USB_OE_N),
        .TX_COUNT     (TX_COUNT)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [35:0] exp_q[$];
    bit   [31:0] model_cnt = 0;
    int          cyc = 0;
    int          txe_mode = 0;
    int          hs_count = 0;
    int          last_hs = 0;
    bit          rec_acc = 0;
    int          acc_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k);
        int guard = 0;
        S_VALID = 1'b1;
        S_DATA  = d;
        S_KEEP  = k;
        @(negedge clk);
        while (!S_READY && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!S_READY) begin
            fail_now("send_timeout");
        end else begin
            exp_q.push_back({k, d});
            hs_count++;
            last_hs = cyc;
        end
        @(posedge clk);
        #1;
        S_VALID = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && USB_WR_N) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound)
            fail_now("drain");
        idle_cycles(GAP + 2);
    endtask

    initial begin
        USB_TXE_N = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (txe_mode)
                0:       USB_TXE_N = 1'b0;
                1:       USB_TXE_N = ($urandom_range(0, 99) < 30);
                default: USB_TXE_N = 1'b1;
            endcase
        end
    end

    // Bus monitor: acceptance = strobe low with TXE_N low at the coming edge.
    initial begin
        bit          prev_valid = 0;
        logic        prev_wr_n = 1'b1;
        bit          prev_acc = 0;
        logic [35:0] prev_word = '0;
        int          acc_run = 0;
        int          hi_run = 0;
        bit          need_gap = 0;
        bit          acc;
        logic [35:0] e;
        forever begin
            @(negedge clk);
            if (!RST_N) begin
                prev_valid = 0;
                acc_run    = 0;
                hi_run     = 0;
                need_gap   = 0;
                continue;
            end
            check("tx_count", TX_COUNT, model_cnt);
            acc = !USB_WR_N && !USB_TXE_N;
            if (prev_valid && !prev_wr_n && !prev_acc) begin
                check("hold_wr_n", USB_WR_N, 1'b0);
                check("hold_word", {USB_BE, USB_DATA}, prev_word);
            end
            if (!USB_WR_N) begin
                if (prev_valid && prev_wr_n && need_gap)
                    check("gap_len_min", hi_run >= GAP, 1'b1);
                need_gap = 0;
                hi_run   = 0;
                if (acc) begin
                    check("burst_len", acc_run < MAXB, 1'b1);
                    acc_run++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %0h expected none", {USB_BE, USB_DATA});
                    end else begin
                        e = exp_q.pop_front();
                        check("word", {USB_BE, USB_DATA}, e);
                    end
                    model_cnt = model_cnt + 1;
                    if (rec_acc)
                        acc_cyc_q.push_back(cyc);
                end
            end else begin
                if (acc_run == MAXB)
                    need_gap = 1;
                acc_run = 0;
                hi_run++;
            end
            prev_valid = 1;
            prev_wr_n  = USB_WR_N;
            prev_acc   = acc;
            prev_word  = {USB_BE, USB_DATA};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_off[10] = '{2, 3, 4, 5, 10, 11, 12, 13, 18, 19};
        int first_hs;
        int base_hs;
        bit [31:0] base_cnt;

        RST_N   = 1'b1;
        S_VALID = 1'b0;
        S_DATA  = '0;
        S_KEEP  = 4'hF;
        TP_EN   = 1'b0;
        #1 RST_N = 1'b0;
        #2;
        check("rst_wr_n", USB_WR_N, 1'b1);
        check("rst_data", USB_DATA, 32'h0);
        check("rst_be", USB_BE, 4'hF);
        check("rst_s_ready", S_READY, 1'b0);
        check("rst_tx_count", TX_COUNT, 32'h0);
        check("tie_rd_oe", {USB_RD_N, USB_OE_N}, 2'b11);
        idle_cycles(3);
        check("rst_hold_s_ready", S_READY, 1'b0);
        RST_N = 1'b1;
        idle_cycles(3);

        // Latency and burst/gap pattern: 10 words back to back, last with partial keep.
        txe_mode = 0;
        idle_cycles(2);
        acc_cyc_q.delete();
        rec_acc  = 1;
        first_hs = 0;
        for (int i = 0; i < 10; i++) begin
            send(32'h10 + i, (i == 9) ? 4'h3 : 4'hF);
            if (i == 0)
                first_hs = last_hs;
        end
        wait_drain(500);
        rec_acc = 0;
        check("burst_words", acc_cyc_q.size(), 10);
        for (int i = 0; i < 10 && i < acc_cyc_q.size(); i++)
            check($sformatf("burst_offset_%0d", i), acc_cyc_q[i] - first_hs, exp_off[i]);
        check("count_after_burst", TX_COUNT, 32'd10);

        // TXE_N high for three cycles in the middle of a stream.
        base_cnt = model_cnt;
        fork
            for (int i = 0; i < 16; i++)
                send(32'h20 + i, 4'hF);
            begin
                idle_cycles(6);
                txe_mode = 2;
                idle_cycles(3);
                txe_mode = 0;
            end
        join
        wait_drain(500);
        check("count_after_stall", TX_COUNT - base_cnt, 32'd16);

        // Fill the FIFO while the FT601 reports full.
        txe_mode = 2;
        idle_cycles(3);
        base_hs  = hs_count;
        base_cnt = model_cnt;
        fork
            for (int i = 0; i < DEPTH + 1; i++)
                send(32'hA0 + i, 4'hF);
            begin
                idle_cycles(DEPTH + 6);
                @(negedge clk);
                check("s_ready_full", S_READY, 1'b0);
                check("fill_count", hs_count - base_hs, DEPTH);
                check("no_write_while_full", USB_WR_N, 1'b1);
                txe_mode = 0;
            end
        join
        wait_drain(500);
        check("count_after_fill", TX_COUNT - base_cnt, DEPTH + 1);

        // Asynchronous reset in the middle of a burst.
        txe_mode = 2;
        idle_cycles(3);
        for (int i = 0; i < 6; i++)
            send(32'hC0 + i, 4'hF);
        txe_mode = 0;
        idle_cycles(3);
        @(negedge clk);
        check("pre_reset_bursting", USB_WR_N, 1'b0);
        @(posedge clk);
        #3 RST_N = 1'b0;
        #1;
        check("midrst_wr_n", USB_WR_N, 1'b1);
        check("midrst_tx_count", TX_COUNT, 32'h0);
        check("midrst_s_ready", S_READY, 1'b0);
        check("midrst_bus", {USB_BE, USB_DATA}, {4'hF, 32'h0});
        exp_q.delete();
        model_cnt = 0;
        idle_cycles(2);
        RST_N = 1'b1;
        idle_cycles(4);
        check("post_reset_idle", USB_WR_N, 1'b1);

        // Randomised traffic with random back-pressure and occasional partial keep.
        txe_mode = 1;
        for (int i = 0; i < 200; i++) begin
            logic [3:0] k;
            k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            send($urandom, k);
            idle_cycles($urandom_range(0, 2));
        end
        wait_drain(5000);
        txe_mode = 0;
        idle_cycles(2);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_count", TX_COUNT, model_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
